// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller sitting in ID; tracks EX/MEM/WB
// producers and registers the operand selects consumed by the execute stage.
module forward_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_shift,
  input  logic             id_aluimm,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       exe_a_select,
  output logic [1:0]       exe_b_select,
  output logic             wb_m2reg,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_OVR = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // Producer slots; only m2reg of the WB slot is observed, so that is all it keeps.
  logic             r_ex_wreg;
  logic             r_ex_m2reg;
  logic [4:0]       r_ex_rd;
  logic             r_mem_wreg;
  logic             r_mem_m2reg;
  logic [4:0]       r_mem_rd;
  logic             r_wb_m2reg;
  logic [1:0]       r_a_sel;
  logic [1:0]       r_b_sel;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_hit_ex_rs;
  logic       w_hit_ex_rt;
  logic       w_hit_mem_rs;
  logic       w_hit_mem_rt;
  logic       w_stall;
  logic       w_take;
  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;

  function automatic logic [1:0] pick_sel(input logic use_r, input logic ovr,
                                          input logic hit_ex, input logic hit_mem);
    if (ovr)                 return SEL_OVR;
    else if (use_r && hit_ex)  return SEL_MEM;
    else if (use_r && hit_mem) return SEL_WB;
    else                     return SEL_REG;
  endfunction

  assign w_hit_ex_rs  = r_ex_wreg  && (r_ex_rd  == id_rs) && (id_rs != 5'd0);
  assign w_hit_ex_rt  = r_ex_wreg  && (r_ex_rd  == id_rt) && (id_rt != 5'd0);
  assign w_hit_mem_rs = r_mem_wreg && (r_mem_rd == id_rs) && (id_rs != 5'd0);
  assign w_hit_mem_rt = r_mem_wreg && (r_mem_rd == id_rt) && (id_rt != 5'd0);

  // A load in EX cannot feed ID yet; overridden operands never stall.
  assign w_stall = id_valid && !flush && r_ex_m2reg &&
                   ((id_use_rs && !id_shift  && w_hit_ex_rs) ||
                    (id_use_rt && !id_aluimm && w_hit_ex_rt));
  assign w_take  = id_valid && !w_stall && !flush;

  assign w_a_sel = pick_sel(id_use_rs, id_shift,  w_hit_ex_rs, w_hit_mem_rs);
  assign w_b_sel = pick_sel(id_use_rt, id_aluimm, w_hit_ex_rt, w_hit_mem_rt);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ex_wreg   <= 1'b0;
      r_ex_m2reg  <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_mem_wreg  <= 1'b0;
      r_mem_m2reg <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_wb_m2reg  <= 1'b0;
      r_a_sel     <= SEL_REG;
      r_b_sel     <= SEL_REG;
      r_stall_cnt <= '0;
    end else begin
      r_ex_wreg   <= w_take ? id_wreg  : 1'b0;
      r_ex_m2reg  <= w_take ? id_m2reg : 1'b0;
      r_ex_rd     <= w_take ? id_rd    : 5'd0;
      r_mem_wreg  <= r_ex_wreg;
      r_mem_m2reg <= r_ex_m2reg;
      r_mem_rd    <= r_ex_rd;
      r_wb_m2reg  <= r_mem_m2reg;
      r_a_sel     <= w_take ? w_a_sel : SEL_REG;
      r_b_sel     <= w_take ? w_b_sel : SEL_REG;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign exe_a_select = r_a_sel;
  assign exe_b_select = r_b_sel;
  assign wb_m2reg     = r_wb_m2reg;
  assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed table-driven bench for forward_ctrl; a narrow counter makes
// saturation reachable in a few cycles.
module tb_forward_ctrl;

  localparam int CW = 2;
  localparam int NV = 30;

  logic          clock = 1'b0;
  logic          resetn;
  logic          id_valid, id_use_rs, id_use_rt, id_shift, id_aluimm;
  logic          id_wreg, id_m2reg, flush;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          stall, wb_m2reg;
  logic [1:0]    exe_a_select, exe_b_select;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  forward_ctrl #(.CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_shift(id_shift), .id_aluimm(id_aluimm),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
    .stall(stall), .exe_a_select(exe_a_select), .exe_b_select(exe_b_select),
    .wb_m2reg(wb_m2reg), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, sh, imm, wr, m2, fl;
    logic       stl;
    logic [1:0] a, b;
    logic       wbm;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(logic v, int rs, int rt, int rd,
                              logic urs, logic urt, logic sh, logic imm,
                              logic wr, logic m2, logic fl,
                              logic stl, logic [1:0] a, logic [1:0] b,
                              logic wbm, int cnt);
    vec_t t;
    t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.urs = urs; t.urt = urt; t.sh = sh; t.imm = imm;
    t.wr = wr; t.m2 = m2; t.fl = fl;
    t.stl = stl; t.a = a; t.b = b; t.wbm = wbm; t.cnt = 2'(cnt);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
    id_use_rs = t.urs; id_use_rt = t.urt; id_shift = t.sh; id_aluimm = t.imm;
    id_wreg = t.wr; id_m2reg = t.m2; flush = t.fl;
  endtask

  initial begin
    vec_t idle;
    // Columns: v rs rt rd urs urt sh imm wr m2 fl | stall a b wbm cnt (a/b/wbm/cnt after the edge)
    tbl[0]  = mk(1, 1, 2, 3,   1,1,0,0,1,0,0, 0, 2'b00,2'b00, 0,0); // add r3
    tbl[1]  = mk(1, 3, 4, 6,   1,1,0,0,1,0,0, 0, 2'b10,2'b00, 0,0); // sub rs=3
    tbl[2]  = mk(1, 8, 9, 5,   1,1,0,0,1,0,0, 0, 2'b00,2'b00, 0,0); // add r5
    tbl[3]  = mk(1, 10,11,12,  1,1,0,0,1,0,0, 0, 2'b00,2'b00, 0,0); // unrelated
    tbl[4]  = mk(1, 2, 5, 13,  1,1,0,0,1,0,0, 0, 2'b00,2'b11, 0,0); // or rt=5 dist 2
    tbl[5]  = mk(1, 1, 0, 7,   1,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,0); // lw r7
    tbl[6]  = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 1, 2'b00,2'b00, 0,1); // add rs=7 stalls
    tbl[7]  = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 0, 2'b11,2'b00, 1,1); // held add resolves
    tbl[8]  = mk(1, 1, 2, 0,   1,1,0,0,1,1,0, 0, 2'b00,2'b00, 0,1); // load to r0
    tbl[9]  = mk(1, 0, 0, 0,   1,1,0,0,0,0,0, 0, 2'b00,2'b00, 0,1); // consumer of r0
    tbl[10] = mk(1, 1, 2, 9,   1,1,0,0,1,0,0, 0, 2'b00,2'b00, 1,1); // producer r9
    tbl[11] = mk(1, 3, 4, 9,   1,1,0,0,1,0,0, 0, 2'b00,2'b00, 0,1); // producer r9 again
    tbl[12] = mk(1, 9, 9, 15,  1,1,0,0,1,0,0, 0, 2'b10,2'b10, 0,1); // youngest wins
    tbl[13] = mk(1, 9, 15,16,  1,1,0,1,1,0,0, 0, 2'b11,2'b01, 0,1); // aluimm override
    tbl[14] = mk(1, 16,15,17,  1,1,1,0,1,0,0, 0, 2'b01,2'b11, 0,1); // shift override
    tbl[15] = mk(1, 1, 2, 7,   0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,1); // lw r7
    tbl[16] = mk(1, 7, 0, 18,  1,0,0,0,1,0,1, 0, 2'b00,2'b00, 0,1); // flushed consumer
    tbl[17] = mk(1, 7, 0, 18,  1,0,0,0,1,0,0, 0, 2'b11,2'b00, 1,1); // consumer, load in MEM
    tbl[18] = mk(1, 1, 2, 20,  0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,1); // lw r20
    tbl[19] = mk(1, 1, 20,21,  0,1,0,1,1,0,0, 0, 2'b00,2'b01, 0,1); // imm hides rt hazard
    tbl[20] = mk(0, 20,20,22,  1,1,0,0,1,0,0, 0, 2'b00,2'b00, 1,1); // invalid ID
    tbl[21] = mk(1, 1, 2, 22,  0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,1); // lw r22
    tbl[22] = mk(1, 0, 22,23,  1,1,0,0,1,0,0, 1, 2'b00,2'b00, 0,2); // rt load-use
    tbl[23] = mk(1, 0, 22,23,  1,1,0,0,1,0,0, 0, 2'b00,2'b11, 1,2);
    tbl[24] = mk(1, 1, 2, 7,   0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,2); // lw r7
    tbl[25] = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 1, 2'b00,2'b00, 0,3);
    tbl[26] = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 0, 2'b11,2'b00, 1,3);
    tbl[27] = mk(1, 1, 2, 7,   0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,3); // lw r7
    tbl[28] = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 1, 2'b00,2'b00, 0,3); // counter saturated
    tbl[29] = mk(1, 7, 8, 14,  1,1,0,0,1,0,0, 0, 2'b11,2'b00, 1,3);

    idle = mk(0, 0,0,0, 0,0,0,0,0,0,0, 0, 2'b00,2'b00, 0,0);
    drive(idle);
    resetn = 1'b0;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_a", 32'(exe_a_select), 0);
    chk("rst_b", 32'(exe_b_select), 0);
    chk("rst_wbm", 32'(wb_m2reg), 0);
    chk("rst_cnt", 32'(stall_count), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clock);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].stl));
      @(posedge clock); #1;
      chk($sformatf("v%0d_a", i), 32'(exe_a_select), 32'(tbl[i].a));
      chk($sformatf("v%0d_b", i), 32'(exe_b_select), 32'(tbl[i].b));
      chk($sformatf("v%0d_wbm", i), 32'(wb_m2reg), 32'(tbl[i].wbm));
      chk($sformatf("v%0d_cnt", i), 32'(stall_count), 32'(tbl[i].cnt));
    end

    // Reset asserted in the middle of a load-use stall cycle.
    drive(mk(1, 1, 2, 7, 0,0,0,0,1,1,0, 0, 2'b00,2'b00, 0,0));
    @(posedge clock); #1;
    drive(mk(1, 7, 8, 14, 1,1,0,0,1,0,0, 0, 2'b00,2'b00, 0,0));
    @(negedge clock);
    chk("mid_stall_pre", 32'(stall), 1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_a", 32'(exe_a_select), 0);
    chk("mid_rst_b", 32'(exe_b_select), 0);
    chk("mid_rst_wbm", 32'(wb_m2reg), 0);
    chk("mid_rst_cnt", 32'(stall_count), 0);
    #1 resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_stall", 32'(stall), 0);
    @(posedge clock); #1;
    chk("post_rst_a", 32'(exe_a_select), 0);
    chk("post_rst_b", 32'(exe_b_select), 0);
    chk("post_rst_cnt", 32'(stall_count), 0);
    drive(idle);
    @(posedge clock); #1;
    chk("post_rst_wbm", 32'(wb_m2reg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
